// File: rtl/serial_mac_unit.sv
// serial_mac_unit: bit-serial shift-and-add multiply-accumulate stage
//
// Sits directly downstream of the right-shift register that holds a vector
// element. It drives that register's load/shift strobes and consumes its
// registered serial output LSB first. Each bit is combined with a latched
// parallel coefficient, and the finished product is added into a running
// dot-product accumulator.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-low reset
//   sys_reset     synchronous, active-high clear (same effect as reset)
//   start         begin one multiply, sampled only while idle
//   acc_clear     synchronous clear of accumulator and overflow
//   multiplicand  coefficient, latched in LOAD
//   serial_in     multiplier bit from the upstream register (registered there)
//   load_o        load strobe to the upstream register
//   shift_o       shift strobe to the upstream register
//   busy          high whenever the FSM is not idle
//   done          one-cycle pulse: product valid and being accumulated
//   product       last product, held until the next LOAD
//   accumulator   running sum, wraps modulo 2^ACC_LENGTH
//   overflow      sticky accumulator overflow
//
// Build option: define SIGNED_MAC_EN for two's-complement operands, a
// sign-extended accumulate and a signed overflow flag.
module serial_mac_unit #(
    parameter int WORD_LENGTH = 8,
    parameter int ACC_LENGTH  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sys_reset,
    input  logic                     start,
    input  logic                     acc_clear,
    input  logic [WORD_LENGTH-1:0]   multiplicand,
    input  logic                     serial_in,
    output logic                     load_o,
    output logic                     shift_o,
    output logic                     busy,
    output logic                     done,
    output logic [2*WORD_LENGTH-1:0] product,
    output logic [ACC_LENGTH-1:0]    accumulator,
    output logic                     overflow
);
    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          sample_idx_q;
    logic                   sample_valid_q;
    logic [WORD_LENGTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]          product_q, product_d, partial, product_step;
    logic [ACC_LENGTH-1:0]  acc_q, acc_d, product_ext, acc_sum;
    logic                   ovf_q, ovf_d, add_ovf;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        load_o  = 1'b0;
        shift_o = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                load_o  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_o = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = DRAIN;
            end
            DRAIN:   state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

`ifdef SIGNED_MAC_EN
    // The multiplier MSB carries negative weight, so its partial product is subtracted.
    assign partial      = PW'($signed(mcand_q)) << sample_idx_q;
    assign product_step = (sample_idx_q == LAST) ? product_q - partial : product_q + partial;
    assign product_ext  = ACC_LENGTH'($signed(product_q));
    assign acc_sum      = acc_q + product_ext;
    assign add_ovf      = (acc_q[ACC_LENGTH-1] == product_ext[ACC_LENGTH-1]) &&
                          (acc_sum[ACC_LENGTH-1] != acc_q[ACC_LENGTH-1]);
`else
    assign partial            = PW'(mcand_q) << sample_idx_q;
    assign product_step       = product_q + partial;
    assign product_ext        = ACC_LENGTH'(product_q);
    assign {add_ovf, acc_sum} = {1'b0, acc_q} + {1'b0, product_ext};
`endif

    // The upstream serial bit lags its shift strobe by one cycle, so bits are
    // consumed against the delayed strobe/index pair; the last one lands in DRAIN.
    always_comb begin
        mcand_d   = (state_q == LOAD) ? multiplicand : mcand_q;
        product_d = (state_q == LOAD) ? '0 :
                    (sample_valid_q && serial_in) ? product_step : product_q;
        acc_d     = acc_clear ? (done ? product_ext : '0) : (done ? acc_sum : acc_q);
        ovf_d     = !acc_clear && (ovf_q || (done && add_ovf));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sample_idx_q   <= '0;
            sample_valid_q <= 1'b0;
            mcand_q        <= '0;
            product_q      <= '0;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
        end else if (sys_reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sample_idx_q   <= '0;
            sample_valid_q <= 1'b0;
            mcand_q        <= '0;
            product_q      <= '0;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sample_idx_q   <= cnt_q;
            sample_valid_q <= shift_o;
            mcand_q        <= mcand_d;
            product_q      <= product_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
        end
    end

    assign product     = product_q;
    assign accumulator = acc_q;
    assign overflow    = ovf_q;
endmodule

// File: doc/serial_mac_unit.md
Name: serial_mac_unit

Overview:
- Bit-serial multiply-accumulate stage for the MxV datapath. It sits directly downstream of the right-shift register that holds a vector element.
- Drives that register's load/shift strobes and consumes its registered serial output, LSB first.
- Multiplies each incoming element by a parallel matrix coefficient using shift-and-add.
- Accumulates successive products into a dot-product accumulator, one per matrix row.

Parameters:
WORD_LENGTH, 8, width of multiplicand and of the serial multiplier word
ACC_LENGTH, 20, accumulator width; must be >= 2*WORD_LENGTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
sys_reset  in  1  synchronous, active-high clear, same effect as reset
start  in  1  begin one multiply; sampled only in IDLE
acc_clear  in  1  synchronous clear of accumulator and overflow
multiplicand  in  WORD_LENGTH  coefficient; latched in LOAD
serial_in  in  1  multiplier bit from upstream shift register serial output
load_o  out  1  load strobe to upstream shift register
shift_o  out  1  shift strobe to upstream shift register
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, product valid and accumulated
product  out  2*WORD_LENGTH  last product; held until next LOAD
accumulator  out  ACC_LENGTH  running sum
overflow  out  1  sticky carry-out of accumulator

Behaviour:
- Reset (async reset=0 or sys_reset=1 at the edge): state IDLE; all outputs 0; bit counter, latched multiplicand and sample pipeline cleared.
- sys_reset has priority over every other input.
- FSM states: IDLE, LOAD, SHIFT, DRAIN, DONE.
- IDLE: start=1 -> LOAD; otherwise stay.
- LOAD (1 cycle): load_o=1; latch multiplicand; clear product; bit counter=0 -> SHIFT.
- SHIFT (exactly WORD_LENGTH cycles): shift_o=1; counter increments each cycle.
  - At counter=WORD_LENGTH-1 -> DRAIN.
- DRAIN (1 cycle): shift_o=0 -> DONE.
- DONE (1 cycle): done=1; accumulator <= accumulator + zero-extended product -> IDLE.
- Upstream serial output is registered, so the bit for shift pulse i is valid one cycle later.
  - Block keeps a 1-cycle-delayed copy of shift_o and of the counter (sample_valid, sample_idx).
  - When sample_valid=1 and serial_in=1: product <= product + (multiplicand << sample_idx).
  - The last bit is sampled in DRAIN.
- Latency: start sampled in cycle t; load_o in t+1; shift_o in t+2..t+W+1; done in t+W+3. For W=8, done is 11 cycles after start.
- Back-to-back: start held high while in DONE is not sampled; the next LOAD occurs no earlier than the cycle after IDLE.
- start in any state other than IDLE is ignored. No queuing.
- load_o and shift_o are never high simultaneously.
- Arithmetic: unsigned. Product width is 2*WORD_LENGTH with no truncation.
- Accumulator add wraps modulo 2^ACC_LENGTH.
  - overflow set on carry-out; stays set until acc_clear, sys_reset or reset.
- acc_clear is honoured in any state without disturbing the FSM.
  - If coincident with DONE: accumulator <= product (clear, then add); overflow <= 0.
- Reset mid-operation: FSM aborts to IDLE immediately; no done pulse; strobes low from the next cycle (async: immediately).

Optional Feature:
- Macro: SIGNED_MAC_EN.
- Defined:
  - multiplicand and multiplier are two's complement.
  - Partial products are sign-extended to 2*WORD_LENGTH.
  - The MSB sample (sample_idx=WORD_LENGTH-1) is subtracted instead of added.
  - product is sign-extended into the accumulator.
  - overflow flags signed overflow (operands same sign, result different sign).
- Undefined: unsigned behaviour as above; no extra logic synthesized.

Test Plan:
- Reset, upstream loaded with 11; start with multiplicand=13 -> done exactly 11 cycles after start, product=143, accumulator=143, overflow=0.
- Without acc_clear, multiply 5 (upstream) by 3 -> product=15, accumulator=158.
- acc_clear, then 255*255 sixteen times -> accumulator=1040400, overflow=0; 17th -> accumulator=56849, overflow=1; acc_clear -> both 0.
- Two boundary cases:
  - start pulsed during SHIFT -> ignored; only one done.
  - acc_clear in the DONE cycle with product=143 -> accumulator=143.
- Two reset cases:
  - sys_reset asserted during 4th SHIFT cycle -> next cycle IDLE, shift_o=0, product=0, accumulator=0, no done.
  - Repeat with async reset low mid-cycle -> outputs 0 before the next edge.
- With SIGNED_MAC_EN: multiplicand=8'hFD (-3), upstream=5 -> product=16'hFFF1 (-15); then multiplicand=8'h7F, upstream=8'h80 -> product=-16256.
